// File: rtl/dm_pkg.sv
// Debug-module shared types for the DMI arbiter.
// Holds the DMI request/response structs, DTM op and DMI response codes, the
// arbiter FSM state type and a small op-classification helper.
package dm;

  localparam int unsigned NUM_REQ = 2;

  // DTM op encoding (2'h3 is illegal and is handled like a NOP)
  localparam logic [1:0] DTM_NOP   = 2'h0;
  localparam logic [1:0] DTM_READ  = 2'h1;
  localparam logic [1:0] DTM_WRITE = 2'h2;

  // DMI response codes
  localparam logic [1:0] DMI_RESP_OK   = 2'h0;
  localparam logic [1:0] DMI_RESP_FAIL = 2'h2;
  localparam logic [1:0] DMI_RESP_BUSY = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    IDLE      = 2'h0,
    FWD       = 2'h1,
    WAIT_RESP = 2'h2,
    RESP      = 2'h3
  } arb_state_e;

  // Only reads and writes travel downstream; everything else is answered locally.
  function automatic logic is_fwd_op(logic [1:0] op);
    return (op == DTM_READ) || (op == DTM_WRITE);
  endfunction

endpackage

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: two-requester DMI arbiter with a single outstanding transaction.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/ready_o[2] per-requester request handshake, req_i[2] payload
//   resp_valid_o/ready_i[2] per-requester response handshake, resp_o shared
//   dmi_req_valid_o/ready_i, dmi_req_o     registered downstream request
//   dmi_resp_valid_i/ready_o, dmi_resp_i   downstream response
//
// Flow: IDLE grants one requester and latches its request. Reads/writes go
// FWD -> WAIT_RESP -> RESP; NOP/illegal ops skip straight to RESP with an OK
// response. WAIT_RESP gives up after RespTimeout cycles with a FAIL response.
// A round-robin pointer (prio) breaks ties and only moves when a response is
// delivered.
module dmi_arbiter
  import dm::*;
#(
  parameter int unsigned RespTimeout = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic      [NUM_REQ-1:0]   req_valid_i,
  output logic      [NUM_REQ-1:0]   req_ready_o,
  input  dmi_req_t  [NUM_REQ-1:0]   req_i,
  output logic      [NUM_REQ-1:0]   resp_valid_o,
  input  logic      [NUM_REQ-1:0]   resp_ready_i,
  output dmi_resp_t                 resp_o,
  output logic                      dmi_req_valid_o,
  input  logic                      dmi_req_ready_i,
  output dmi_req_t                  dmi_req_o,
  input  logic                      dmi_resp_valid_i,
  output logic                      dmi_resp_ready_o,
  input  dmi_resp_t                 dmi_resp_i
);

  localparam logic [15:0] CntLast = 16'(RespTimeout - 1);

  arb_state_e state_q, state_d;
  logic       prio_q;
  logic       grant_q;
  dmi_req_t   req_q;
  dmi_resp_t  resp_q, resp_d;
  logic [15:0] cnt_q;

  logic grant_sel;
  logic any_valid;
  logic load_req, load_resp;
  logic cnt_clr, cnt_inc;
  logic prio_upd;

  // Single requester wins outright; on contention the pointer decides.
  assign any_valid = |req_valid_i;
  assign grant_sel = (&req_valid_i) ? prio_q : req_valid_i[1];

  always_comb begin
    state_d          = state_q;
    req_ready_o      = '0;
    resp_valid_o     = '0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    load_req         = 1'b0;
    load_resp        = 1'b0;
    resp_d           = resp_q;
    cnt_clr          = 1'b0;
    cnt_inc          = 1'b0;
    prio_upd         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Stay receptive downstream so a response that arrives after a
        // timeout is drained instead of wedging the slave.
        dmi_resp_ready_o = 1'b1;
        if (any_valid) begin
          req_ready_o[grant_sel] = 1'b1;
          load_req               = 1'b1;
          if (is_fwd_op(req_i[grant_sel].op)) begin
            state_d = FWD;
          end else begin
            state_d   = RESP;
            load_resp = 1'b1;
            resp_d    = '{data: 32'h0, resp: DMI_RESP_OK};
          end
        end
      end

      FWD: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          state_d = WAIT_RESP;
          cnt_clr = 1'b1;
        end
      end

      WAIT_RESP: begin
        dmi_resp_ready_o = 1'b1;
        // A response on the final cycle still beats the timeout.
        if (dmi_resp_valid_i) begin
          state_d   = RESP;
          load_resp = 1'b1;
          resp_d    = dmi_resp_i;
        end else if (cnt_q == CntLast) begin
          state_d   = RESP;
          load_resp = 1'b1;
          resp_d    = '{data: 32'h0, resp: DMI_RESP_FAIL};
        end else begin
          cnt_inc = 1'b1;
        end
      end

      RESP: begin
        resp_valid_o[grant_q] = 1'b1;
        if (resp_ready_i[grant_q]) begin
          state_d  = IDLE;
          prio_upd = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      req_q   <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_req) begin
        req_q   <= req_i[grant_sel];
        grant_q <= grant_sel;
      end
      if (load_resp) resp_q <= resp_d;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 16'd1;
      if (prio_upd) prio_q <= ~grant_q;
    end
  end

  // Downstream request comes straight from the latch, so it cannot move
  // while dmi_req_valid_o is held in FWD.
  assign dmi_req_o = req_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: directed scenarios followed by a
// randomized phase with a scoreboard fed from a behavioural model.
module tb_dmi_arbiter;
  import dm::*;

  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic      [1:0] req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
  dmi_req_t  [1:0] req_i;
  dmi_resp_t       resp_o, dmi_resp_i;
  logic            dmi_req_valid_o, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_ready_o;
  dmi_req_t        dmi_req_o;

  dmi_arbiter #(.RespTimeout(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i), .dmi_req_o(dmi_req_o),
    .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_i(dmi_resp_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- environment / reference model ----------------
  // Downstream slave behaviour used in the random phase.
  function automatic dmi_resp_t ds_resp(input dmi_req_t r);
    dmi_resp_t x;
    x.data = r.data ^ {25'h0, r.addr} ^ 32'hA5A5_0000;
    x.resp = (r.op == DTM_WRITE && r.addr[3]) ? DMI_RESP_BUSY : DMI_RESP_OK;
    return x;
  endfunction

  function automatic logic ds_drops(input dmi_req_t r);
    return r.addr[6:4] == 3'h7;
  endfunction

  function automatic dmi_resp_t model_resp(input dmi_req_t r);
    dmi_resp_t x;
    if (r.op != DTM_READ && r.op != DTM_WRITE) x = '{data: 32'h0, resp: DMI_RESP_OK};
    else if (ds_drops(r))                      x = '{data: 32'h0, resp: DMI_RESP_FAIL};
    else                                       x = ds_resp(r);
    return x;
  endfunction

  // ---------------- scoreboard monitor ----------------
  bit        sb_on = 0;
  dmi_resp_t q0[$], q1[$];
  dmi_req_t  ds_q[$];
  logic      m_prio;
  logic      pv, pr;
  dmi_req_t  preq;
  logic      mon_g, mon_a;
  dmi_resp_t mon_e;
  int        n_resp = 0;

  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      if (req_ready_o != 2'b00) begin
        if (req_valid_i != 2'b00) begin
          mon_g = (req_valid_i == 2'b11) ? m_prio : req_valid_i[1];
          chk("grant", req_ready_o, mon_g ? 2'b10 : 2'b01);
        end else begin
          chk("ready_without_valid", req_ready_o, 2'b00);
        end
        mon_a = req_ready_o[1];
        if (req_valid_i[mon_a]) begin
          if (mon_a) q1.push_back(model_resp(req_i[1]));
          else       q0.push_back(model_resp(req_i[0]));
          if (req_i[mon_a].op == DTM_READ || req_i[mon_a].op == DTM_WRITE)
            ds_q.push_back(req_i[mon_a]);
        end
      end
      if (dmi_req_valid_o && dmi_req_ready_i) begin
        if (ds_q.size() == 0) chk("ds_req_unexpected", dmi_req_valid_o, 1'b0);
        else                  chk("ds_req", dmi_req_o, ds_q.pop_front());
      end
      if (pv && !pr) chk("ds_stable", {dmi_req_valid_o, dmi_req_o}, {1'b1, preq});
      pv = dmi_req_valid_o; pr = dmi_req_ready_i; preq = dmi_req_o;
      if (resp_valid_o != 2'b00) begin
        if (resp_valid_o == 2'b11) chk("resp_onehot", resp_valid_o, 2'b01);
        mon_a = resp_valid_o[1];
        if (resp_ready_i[mon_a]) begin
          if ((mon_a ? q1.size() : q0.size()) == 0) begin
            chk("resp_unexpected", resp_valid_o, 2'b00);
          end else begin
            mon_e = mon_a ? q1.pop_front() : q0.pop_front();
            chk(mon_a ? "resp1" : "resp0", resp_o, mon_e);
            n_resp++;
          end
          m_prio = ~mon_a;
        end
      end
    end else begin
      pv = 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid_i = '0; resp_ready_i = '0; dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
    q0.delete(); q1.delete(); ds_q.delete();
    m_prio = 1'b0; pv = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    dmi_req_t  r, r1;
    logic      p, g;
    logic [1:0] acc;
    bit        hs_req, hs_resp, pend, issuing;
    int        cd;
    dmi_req_t  dr, dr_pend;

    req_valid_i = '0; req_i = '0; resp_ready_i = '0;
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0; dmi_resp_i = '0;
    #2;
    chk("rst_dmi_req_valid", dmi_req_valid_o, 1'b0);
    chk("rst_resp_valid", resp_valid_o, 2'b00);
    chk("rst_dmi_resp_ready", dmi_resp_ready_o, 1'b1);
    chk("rst_dmi_req", dmi_req_o, '0);
    chk("rst_resp_o", resp_o, '0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Req0 READ 0x11, zero-wait downstream: response on cycle 4
    r = '{addr: 7'h11, data: 32'h0, op: DTM_READ};
    req_i[0] = r; req_valid_i = 2'b01; dmi_req_ready_i = 1'b1; resp_ready_i = 2'b01;
    #1 chk("t033_ready", req_ready_o, 2'b01);
    tick(); req_valid_i = 2'b00;
    chk("t033_fwd", {dmi_req_valid_o, dmi_req_o}, {1'b1, r});
    tick(); dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'hDEADBEEF, resp: DMI_RESP_OK};
    chk("t033_wait_ready", {resp_valid_o, dmi_resp_ready_o}, 3'b001);
    tick(); dmi_resp_valid_i = 1'b0;
    chk("t033_resp", {resp_valid_o, resp_o}, {2'b01, 32'hDEADBEEF, 2'h0});
    tick();
    chk("t033_idle", resp_valid_o, 2'b00);

    // Both valid continuously, 4 writes: round-robin
    do_reset();
    req_i[0] = '{addr: 7'h20, data: 32'h1000, op: DTM_WRITE};
    req_i[1] = '{addr: 7'h21, data: 32'h2000, op: DTM_WRITE};
    req_valid_i = 2'b11; dmi_req_ready_i = 1'b1; resp_ready_i = 2'b11;
    p = 1'b0;
    for (int k = 0; k < 4; k++) begin
      g = p;
      #1 chk("t034_grant", req_ready_o, g ? 2'b10 : 2'b01);
      tick();
      chk("t034_fwd_addr", dmi_req_o.addr, g ? 7'h21 : 7'h20);
      tick(); dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'(k), resp: DMI_RESP_OK};
      tick(); dmi_resp_valid_i = 1'b0;
      chk("t034_resp", {resp_valid_o, resp_o}, {(g ? 2'b10 : 2'b01), 32'(k), 2'h0});
      p = ~g;
      tick();
    end
    req_valid_i = 2'b00;

    // Req1 READ, no downstream response: timeout after T WAIT_RESP cycles
    r1 = '{addr: 7'h22, data: 32'h0, op: DTM_READ};
    req_i[1] = r1; req_valid_i = 2'b10; resp_ready_i = 2'b10;
    #1 chk("t035_ready", req_ready_o, 2'b10);
    tick(); req_valid_i = 2'b00;
    tick();
    for (int c = 0; c < T; c++) begin
      chk("t035_wait", {resp_valid_o, dmi_resp_ready_o}, 3'b001);
      tick();
    end
    chk("t035_fail", {resp_valid_o, resp_o}, {2'b10, 32'h0, 2'h2});
    tick(); tick(); tick();
    dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'h5555AAAA, resp: DMI_RESP_OK};
    chk("t035_late_ready", dmi_resp_ready_o, 1'b1);
    tick(); dmi_resp_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t035_late_dropped", {resp_valid_o, dmi_req_valid_o}, 3'b000);
      tick();
    end

    // Req0 NOP: straight to RESP with {0, OK}, nothing downstream
    req_i[0] = '{addr: 7'h05, data: 32'h1234, op: DTM_NOP};
    req_valid_i = 2'b01; resp_ready_i = 2'b01;
    #1 chk("t036_ready", req_ready_o, 2'b01);
    tick(); req_valid_i = 2'b00;
    chk("t036_resp", {resp_valid_o, dmi_req_valid_o, resp_o}, {2'b01, 1'b0, 34'h0});
    tick();
    chk("t036_idle", {resp_valid_o, dmi_req_valid_o}, 3'b000);

    // Reset during WAIT_RESP (prio is 1 here after req0 completed)
    req_i[0] = '{addr: 7'h33, data: 32'h0, op: DTM_READ};
    req_valid_i = 2'b01;
    tick(); req_valid_i = 2'b00;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 chk("t037_async", {resp_valid_o, dmi_req_valid_o, dmi_resp_ready_o, dmi_req_o}, {2'b00, 1'b0, 1'b1, 41'h0});
    tick();
    chk("t037_no_resp", resp_valid_o, 2'b00);
    rst_n = 1'b1;
    r  = '{addr: 7'h44, data: 32'hAAAA0000, op: DTM_WRITE};
    r1 = '{addr: 7'h55, data: 32'hBBBB0000, op: DTM_WRITE};
    req_i[0] = r; req_i[1] = r1; req_valid_i = 2'b11; resp_ready_i = 2'b11; dmi_req_ready_i = 1'b1;
    #1 chk("t037_grant_prio0", req_ready_o, 2'b01);
    tick(); req_valid_i = 2'b00;
    chk("t037_fwd", dmi_req_o, r);
    tick(); dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'h77, resp: DMI_RESP_OK};
    tick(); dmi_resp_valid_i = 1'b0;
    chk("t037_resp", {resp_valid_o, resp_o}, {2'b01, 32'h77, 2'h0});
    tick();

    // Downstream stall in FWD, then response on the last WAIT_RESP cycle
    r = '{addr: 7'h66, data: 32'h600D600D, op: DTM_WRITE};
    req_i[0] = r; req_valid_i = 2'b01; dmi_req_ready_i = 1'b0; resp_ready_i = 2'b01;
    tick(); req_valid_i = 2'b00;
    for (int c = 0; c < 5; c++) begin
      chk("t038_hold", {dmi_req_valid_o, dmi_req_o}, {1'b1, r});
      tick();
    end
    dmi_req_ready_i = 1'b1;
    chk("t038_hold_last", {dmi_req_valid_o, dmi_req_o}, {1'b1, r});
    tick();
    for (int c = 0; c < T - 1; c++) begin
      chk("t038_wait", {resp_valid_o, dmi_req_valid_o}, 3'b000);
      tick();
    end
    dmi_resp_valid_i = 1'b1; dmi_resp_i = '{data: 32'hCAFE0001, resp: DMI_RESP_OK};
    tick(); dmi_resp_valid_i = 1'b0;
    chk("t038_resp_wins", {resp_valid_o, resp_o}, {2'b01, 32'hCAFE0001, 2'h0});
    tick();

    // Randomized phase with scoreboard
    do_reset();
    sb_on = 1;
    pend = 0; cd = 0; issuing = 1; dr_pend = '0;
    for (int cyc = 0; cyc < 3200; cyc++) begin
      if (cyc == 3000) issuing = 0;
      @(negedge clk);
      acc     = req_valid_i & req_ready_o;
      hs_req  = dmi_req_valid_o & dmi_req_ready_i;
      hs_resp = dmi_resp_valid_i & dmi_resp_ready_o;
      dr      = dmi_req_o;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !req_valid_i[i]) begin
          if (issuing && $urandom_range(0, 2) == 0) begin
            req_valid_i[i]   = 1'b1;
            req_i[i].op      = 2'($urandom_range(0, 3));
            req_i[i].addr    = 7'($urandom);
            req_i[i].data    = $urandom;
          end else begin
            req_valid_i[i] = 1'b0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid_i[i] = 1'b0;
        end
        resp_ready_i[i] = ($urandom_range(0, 3) != 0);
      end
      dmi_req_ready_i = ($urandom_range(0, 2) != 0);
      if (hs_resp) dmi_resp_valid_i = 1'b0;
      if (hs_req && !ds_drops(dr)) begin
        pend = 1; cd = int'(dr.addr[2:0]); dr_pend = dr;
      end
      if (pend) begin
        if (cd == 0) begin
          dmi_resp_valid_i = 1'b1; dmi_resp_i = ds_resp(dr_pend); pend = 0;
        end else begin
          cd--;
        end
      end
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_ds", ds_q.size(), 0);
    chk("random_activity", n_resp > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
